// File: rtl/seq_mul_pkg.sv
// Shared definitions for the time-shared 16x16 multiplier: FSM encoding,
// tile geometry and the per-step shift helper.
package seq_mul_pkg;

    localparam int TILE_W = 8;
    localparam int STEPS  = 4;
    localparam int STEP_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [STEP_W-1:0] step_t;

    // Left shift applied to a tile product before it is accumulated.
    // Step 0 is lo*lo, steps 1 and 2 are the cross terms, step 3 is hi*hi.
    function automatic logic [4:0] step_shift(input step_t s);
        case (s)
            2'd0:    step_shift = 5'd0;
            2'd3:    step_shift = 5'(2 * TILE_W);
            default: step_shift = 5'(TILE_W);
        endcase
    endfunction

endpackage

// File: rtl/seq_tile_mul16_tile.sv
// mul8_tile: purely combinational 8x8 unsigned multiplier, the only
// multiplier in the block. Operands are zero-extended so the product is
// computed at full result width.
module mul8_tile
    import seq_mul_pkg::*;
(
    input  logic [TILE_W-1:0]   a,
    input  logic [TILE_W-1:0]   b,
    output logic [2*TILE_W-1:0] p
);

    logic [2*TILE_W-1:0] a_ext;
    logic [2*TILE_W-1:0] b_ext;

    assign a_ext = {{TILE_W{1'b0}}, a};
    assign b_ext = {{TILE_W{1'b0}}, b};
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/seq_tile_mul16.sv
// seq_tile_mul16: 16x16 -> 32 unsigned multiplier that reuses one 8x8 tile
// over up to four MUL cycles. Operand bytes are taken from the latched
// operands, the tile product feeds the accumulator adder in the same cycle.
// With SKIP_ZERO set, cross/high steps whose tile would see a zero byte
// are skipped entirely.
module seq_tile_mul16
    import seq_mul_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        busy
);

    state_t              state;
    logic [15:0]         a_q;
    logic [15:0]         b_q;
    logic [31:0]         acc;
    step_t               step;

    logic [TILE_W-1:0]   a_lo, a_hi, b_lo, b_hi;
    logic [TILE_W-1:0]   tile_a, tile_b;
    logic [2*TILE_W-1:0] tile_p;
    logic [31:0]         addend;
    logic [STEPS-1:0]    step_live;
    logic                has_next;
    step_t               next_step;
    logic                accept;

    assign a_lo = a_q[TILE_W-1:0];
    assign a_hi = a_q[2*TILE_W-1:TILE_W];
    assign b_lo = b_q[TILE_W-1:0];
    assign b_hi = b_q[2*TILE_W-1:TILE_W];

    // Step 0 always runs; the others only run if both their bytes are nonzero.
    assign step_live[0] = 1'b1;
    assign step_live[1] = !SKIP_ZERO || ((a_hi != '0) && (b_lo != '0));
    assign step_live[2] = !SKIP_ZERO || ((a_lo != '0) && (b_hi != '0));
    assign step_live[3] = !SKIP_ZERO || ((a_hi != '0) && (b_hi != '0));

    // Route the operand bytes of the current step into the shared tile.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        tile_a = a_lo;
        tile_b = b_lo;
        case (step)
            2'd1: tile_a = a_hi;
            2'd2: tile_b = b_hi;
            2'd3: begin
                tile_a = a_hi;
                tile_b = b_hi;
            end
            default: ;
        endcase
    end

    mul8_tile u_tile (
        .a (tile_a),
        .b (tile_b),
        .p (tile_p)
    );

    assign addend = {{(32 - 2*TILE_W){1'b0}}, tile_p} << step_shift(step);

    // Find the lowest live step after the current one; none means finish.
    always_comb begin
        has_next  = 1'b0;
        next_step = step;
        for (int s = STEPS - 1; s > 0; s--) begin
            if ((s > int'(step)) && step_live[s]) begin
                has_next  = 1'b1;
                next_step = step_t'(s);
            end
        end
    end

    // A completed product can be replaced in the cycle it is taken.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign out      = acc;

    // Control FSM with datapath registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            step      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc   <= '0;
                        step  <= '0;
                        state <= MUL;
                        busy  <= 1'b1;
                    end
                end
                MUL: begin
                    acc <= acc + addend;
                    if (has_next) begin
                        step <= next_step;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            a_q   <= a;
                            b_q   <= b;
                            acc   <= '0;
                            step  <= '0;
                            state <= MUL;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_tile_mul16.sv
// Directed bench for seq_tile_mul16: a SKIP_ZERO=1 instance for the bulk of
// the vectors and a SKIP_ZERO=0 instance for the fixed-latency case.
module tb_seq_tile_mul16;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] a, b;
    logic [31:0] out;

    logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
    logic [15:0] a0, b0;
    logic [31:0] out0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_tile_mul16 #(.SKIP_ZERO(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    seq_tile_mul16 #(.SKIP_ZERO(1'b0)) dut_noskip (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .a         (a0),
        .b         (b0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out       (out0),
        .busy      (busy0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Offer one operand pair from IDLE, scramble the inputs during MUL (they
    // must be ignored), and wait for out_valid. Leaves the DUT stalled in DONE.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] exp, input int exp_cyc);
        int cyc;
        bit seen;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        a   = ~av;
        b   = ~bv;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            cyc++;
            #1;
            if (out_valid) seen = 1'b1;
        end
        in_valid = 1'b0;
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_out"}, out, exp);
    endtask

    // Consumer takes the product with nothing new offered: back to IDLE.
    task automatic release_op(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rel_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        in_valid0 = 1'b0; a0 = '0; b0 = '0; out_ready0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out", out, 32'd0);
        check("rst_in_ready0", 32'(in_ready0), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Full four-step products.
        run_op("v1234x5678", 16'h1234, 16'h5678, 32'h06260060, 4);
        check("v1234_busy", 32'(busy), 32'd1);
        check("v1234_in_ready_stall", 32'(in_ready), 32'd0);
        release_op("v1234");
        run_op("vffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 4);
        release_op("vffff");

        // Zero-byte skipping patterns.
        run_op("v00ff", 16'h00FF, 16'h00FF, 32'h0000FE01, 1);
        release_op("v00ff");
        run_op("vcross1", 16'h0100, 16'h0003, 32'h00000300, 2);
        release_op("vcross1");
        run_op("vcross2", 16'h0003, 16'h0200, 32'h00000600, 2);
        release_op("vcross2");
        run_op("vhihi", 16'h8000, 16'h8000, 32'h40000000, 2);
        release_op("vhihi");
        run_op("vzero", 16'h0000, 16'h1234, 32'h00000000, 1);
        release_op("vzero");

        // Same low-byte product without skipping always takes four cycles.
        @(negedge clk);
        in_valid0 = 1'b1; a0 = 16'h00FF; b0 = 16'h00FF;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            cyc++;
            #1;
            if (out_valid0) seen = 1'b1;
        end
        check("noskip_cycles", 32'(cyc), 32'd4);
        check("noskip_out", out0, 32'h0000FE01);
        @(negedge clk);
        out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        out_ready0 = 1'b0;
        check("noskip_rel_valid", 32'(out_valid0), 32'd0);

        // Long stall in DONE, then back-to-back accept of 2*3.
        run_op("stall", 16'h0102, 16'h0304, 32'h00030A08, 4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_out", out, 32'h00030A08);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; a = 16'd2; b = 16'd3;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_valid_drop", 32'(out_valid), 32'd0);
        check("b2b_busy_no_idle", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_out", out, 32'h00000006);
        release_op("b2b");

        // Reset while step 2 is pending abandons the product.
        @(negedge clk);
        in_valid = 1'b1; a = 16'h1234; b = 16'h5678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op("after_rst", 16'h0002, 16'h0003, 32'h00000006, 1);
        release_op("after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_tile_mul16.md
SEQ_TILE_MUL16 -- requirements
Module: seq_tile_mul16

Interface
REQ-001 SHALL have parameter: SKIP_ZERO, 1, when 1 skip tile steps whose operand byte is zero.
REQ-002 SHALL have port: clk  input  1  single clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port: a  input  16  unsigned multiplicand.
REQ-007 SHALL have port: b  input  16  unsigned multiplier.
REQ-008 SHALL have port: out_valid  output  1  product available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes product.
REQ-010 SHALL have port: out  output  32  product, modulo 2^32.
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL compute a*b by time-sharing one 8x8 unsigned tile multiplier (16-bit result) across up to four steps, accumulating into a 32-bit register.
REQ-013 SHALL implement FSM states IDLE, MUL, DONE.
REQ-014 SHALL transfer operands on a clock edge where in_valid and in_ready are both high; a and b are latched, the accumulator cleared, step index set to 0, state goes to MUL.
REQ-015 SHALL drive in_ready high in IDLE, and in DONE only while out_ready is high; low in MUL.
REQ-016 SHALL execute steps in fixed order: 0 = a[7:0]*b[7:0] shift 0; 1 = a[15:8]*b[7:0] shift 8; 2 = a[7:0]*b[15:8] shift 8; 3 = a[15:8]*b[15:8] shift 16.
REQ-017 SHALL execute one step per MUL cycle, adding the shifted tile result to the accumulator modulo 2^32.
REQ-018 SHALL always execute step 0; with SKIP_ZERO=1, SHALL skip steps 1-3 when either of their tile operand bytes is zero, consuming no cycle for skipped steps.
REQ-019 SHALL leave MUL for DONE after the last non-skipped step; MUL therefore lasts 1-4 cycles (always 4 when SKIP_ZERO=0).
REQ-020 SHALL hold out_valid high and out stable throughout DONE until out_ready is high.
REQ-021 SHALL, in DONE with out_ready high and in_valid low, go to IDLE; with in_valid also high, accept the new operands in the same cycle and go directly to MUL (back-to-back, no bubble).
REQ-022 SHALL ignore in_valid and operand changes while in MUL.
REQ-023 SHALL keep out equal to the accumulator; out is only specified while out_valid is high.

Reset
REQ-024 SHALL, on rst high, immediately enter IDLE with out_valid=0, busy=0, in_ready=1, accumulator=0, operand registers=0, step index=0.
REQ-025 SHALL abandon any operation in progress, without producing out_valid, when rst asserts mid-MUL or mid-DONE.

Structure
REQ-026 SHALL take state encoding (IDLE/MUL/DONE), step count (4) and tile width (8) from a shared package seq_mul_pkg.
REQ-027 SHALL instantiate exactly one sub-module, mul8_tile (8x8 unsigned, combinational, 16-bit output), with no other multiplier in the block.
REQ-028 SHALL register tile operands or the tile result, not both; combinational tile-to-accumulator path within one cycle.

Verification (exact mul8_tile)
REQ-029 SHALL check a=0x1234, b=0x5678, SKIP_ZERO=1 -> out=0x06260060, out_valid 4 cycles after the accepting edge.
REQ-030 SHALL check a=0xFFFF, b=0xFFFF -> out=0xFFFE0001, 4 MUL cycles.
REQ-031 SHALL check a=0x00FF, b=0x00FF, SKIP_ZERO=1 -> out=0x0000FE01 after 1 MUL cycle; SKIP_ZERO=0 -> same value after 4 MUL cycles.
REQ-032 SHALL check out_ready held low 10 cycles in DONE -> out stable, in_ready low; then out_ready=1 with in_valid=1 (a=2, b=3) -> next out=0x00000006, no IDLE cycle.
REQ-033 SHALL check rst pulsed during step 2 of 0x1234*0x5678 -> out_valid stays 0, in_ready=1 next cycle, next operation 0x0002*0x0003 -> 0x00000006.
